// File: rtl/arm_mem_pkg.sv
// Shared types and default widths for the Mem-stage SRAM controller.
// This package is common to both builds, with or without SRAM_READ_CACHE_EN.
package arm_mem_pkg;

  localparam int WORD_W    = 32;
  localparam int SRAM_DW   = 16;
  localparam int SRAM_AW   = 18;
  localparam int BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state counter for one half-word phase: counts 0..ACCESS_CYCLES-1 and flags the final cycle.
module sram_phase_counter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int CNT_W         = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last_cycle
);

  // Phase counter; wraps to zero after the last cycle so HIGH starts fresh after LOW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (en) begin
      count <= last_cycle ? {CNT_W{1'b0}} : count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign last_cycle = (count == CNT_W'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit Mem-stage loads/stores into two wait-stated 16-bit asynchronous SRAM accesses.
// Optional SRAM_READ_CACHE_EN adds a one-entry read buffer that answers repeat reads without stalling.
module sram_controller #(
  parameter int WORD_W        = arm_mem_pkg::WORD_W,
  parameter int SRAM_DW       = arm_mem_pkg::SRAM_DW,
  parameter int SRAM_AW       = arm_mem_pkg::SRAM_AW,
  parameter int BASE_ADDR     = arm_mem_pkg::BASE_ADDR,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  write_data,
  output logic [WORD_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);
  import arm_mem_pkg::*;

  localparam int TAG_W = SRAM_AW - 1;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_e            state_r;
  logic              is_write_r;
  logic [TAG_W-1:0]  tag_r;
  logic [WORD_W-1:0] wdata_r;
  logic [WORD_W-1:0] read_data_r;
  logic [WORD_W-1:0] offset_s;
  logic [TAG_W-1:0]  tag_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              last_s;
  logic              penult_s;
  logic              hit_s;
  logic              ready_s;

  // Word tag: bits [SRAM_AW:2] of the rebased byte address; the low two bits drop out.
  assign offset_s = address - WORD_W'(BASE_ADDR);
  assign tag_s    = TAG_W'(offset_s >> 2);
  assign penult_s = (cnt_s == CNT_W'(ACCESS_CYCLES - 2));

  sram_phase_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES),
    .CNT_W        (CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state_r == IDLE) || (state_r == DONE)),
    .en        ((state_r == LOW) || (state_r == HIGH)),
    .count     (cnt_s),
    .last_cycle(last_s)
  );

`ifdef SRAM_READ_CACHE_EN
  logic              cache_valid_r;
  logic [TAG_W-1:0]  cache_tag_r;
  logic [WORD_W-1:0] cache_data_r;

  assign hit_s = (state_r == IDLE) && rd_en && !wr_en && cache_valid_r && (cache_tag_r == tag_s);
  assign read_data = hit_s ? cache_data_r : read_data_r;

  // Read buffer: filled by every completed read, invalidated by a store to the same word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_r <= 1'b0;
      cache_tag_r   <= {TAG_W{1'b0}};
      cache_data_r  <= {WORD_W{1'b0}};
    end else if (state_r == HIGH && last_s && !is_write_r) begin
      cache_valid_r <= 1'b1;
      cache_tag_r   <= tag_r;
      cache_data_r  <= {sram_dq_in, read_data_r[SRAM_DW-1:0]};
    end else if (state_r == IDLE && wr_en && cache_tag_r == tag_s) begin
      cache_valid_r <= 1'b0;
    end else begin
      cache_valid_r <= cache_valid_r;
    end
  end
`else
  assign hit_s     = 1'b0;
  assign read_data = read_data_r;
`endif

  // Handshake back to the pipeline; combinational so a new request stalls in its first cycle.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = !(wr_en || rd_en) || hit_s;
      DONE:    ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end
  assign ready = ready_s;

  // Access sequencer; SRAM pins are set up one cycle ahead so they are registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      is_write_r  <= 1'b0;
      tag_r       <= {TAG_W{1'b0}};
      wdata_r     <= {WORD_W{1'b0}};
      read_data_r <= {WORD_W{1'b0}};
      sram_addr   <= {SRAM_AW{1'b0}};
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= {SRAM_DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if ((wr_en || rd_en) && !hit_s) begin
            state_r     <= LOW;
            is_write_r  <= wr_en;
            tag_r       <= tag_s;
            wdata_r     <= write_data;
            sram_addr   <= {tag_s, 1'b0};
            sram_we_n   <= !wr_en;
            sram_dq_oe  <= wr_en;
            sram_dq_out <= write_data[SRAM_DW-1:0];
          end
        end
        LOW: begin
          if (last_s) begin
            state_r     <= HIGH;
            sram_addr   <= {tag_r, 1'b1};
            sram_we_n   <= !is_write_r;
            sram_dq_out <= wdata_r[WORD_W-1:SRAM_DW];
            if (!is_write_r) begin
              read_data_r[SRAM_DW-1:0] <= sram_dq_in;
            end
          end else begin
            // Release the strobe on the final cycle so data is held past the write edge.
            sram_we_n <= !is_write_r || penult_s;
          end
        end
        HIGH: begin
          if (last_s) begin
            state_r    <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_write_r) begin
              read_data_r[WORD_W-1:SRAM_DW] <= sram_dq_in;
            end
          end else begin
            sram_we_n <= !is_write_r || penult_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a behavioural 16-bit SRAM.
// Also covers the SRAM_READ_CACHE_EN build when that macro is defined.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  logic [15:0] mem [0:262143];

  int checks = 0;
  int errors = 0;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write captured while the strobe is low.
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) begin
    if (rst && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access: ready low on cycles 0..6, phases on cycles 1..3 (half 0) and 4..6 (half 1).
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input int drop_at, input logic [17:0] exp_addr0, input logic [31:0] exp_rd);
    logic is_wr;
    logic half;
    is_wr      = w;
    wr_en      = w;
    rd_en      = r;
    address    = a;
    write_data = d;
    #1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      chk($sformatf("ready c%0d", cyc), {31'd0, ready}, {31'd0, (cyc == 7)});
      if (cyc >= 1 && cyc <= 6) begin
        half = (cyc >= 4);
        chk($sformatf("sram_addr c%0d", cyc), {14'd0, sram_addr}, {14'd0, exp_addr0 + {17'd0, half}});
        chk($sformatf("dq_oe c%0d", cyc), {31'd0, sram_dq_oe}, {31'd0, is_wr});
        chk($sformatf("we_n c%0d", cyc), {31'd0, sram_we_n},
            {31'd0, (!is_wr || cyc == 3 || cyc == 6)});
        if (is_wr) chk($sformatf("dq_out c%0d", cyc), {16'd0, sram_dq_out}, {16'd0, half ? d[31:16] : d[15:0]});
      end
      if (cyc == 7) chk("read_data done", read_data, exp_rd);
      if (cyc == drop_at || cyc == 7) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
      tick();
    end
    chk("ready idle after", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    tick();
    tick();
    chk("reset we_n", {31'd0, sram_we_n}, 32'd1);
    chk("reset dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("reset sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("reset dq_out", {16'd0, sram_dq_out}, 32'd0);
    chk("reset read_data", read_data, 32'd0);
    chk("reset ready", {31'd0, ready}, 32'd1);
    rst = 1'b1;
    tick();

    // Store then load back the first word.
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1, 18'd0, 32'd0);
    chk("mem[0]", {16'd0, mem[0]}, 32'h0000BEEF);
    chk("mem[1]", {16'd0, mem[1]}, 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'd0, -1, 18'd0, 32'hDEADBEEF);

    // Address map: 1036 -> SRAM 6/7, and low byte bits are ignored.
    access(1'b1, 1'b0, 32'd1036, 32'h22221111, -1, 18'd6, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1036, 32'd0, -1, 18'd6, 32'h22221111);
    access(1'b1, 1'b0, 32'd1039, 32'h22221111, -1, 18'd6, 32'h22221111);
    access(1'b0, 1'b1, 32'd1039, 32'd0, -1, 18'd6, 32'h22221111);

    // Both enables: the store wins, load data untouched.
    access(1'b1, 1'b1, 32'd1040, 32'h12345678, -1, 18'd8, 32'h22221111);
    chk("mem[8]", {16'd0, mem[8]}, 32'h00005678);
    chk("mem[9]", {16'd0, mem[9]}, 32'h00001234);

    // Request dropped in LOW still completes and updates read_data.
    access(1'b0, 1'b1, 32'd1024, 32'd0, 1, 18'd0, 32'hDEADBEEF);

`ifdef SRAM_READ_CACHE_EN
    rd_en   = 1'b1;
    address = 32'd1024;
    #1;
    chk("cache hit ready", {31'd0, ready}, 32'd1);
    chk("cache hit data", read_data, 32'hDEADBEEF);
    tick();
    chk("cache hit stays idle", {31'd0, ready}, 32'd1);
    rd_en = 1'b0;
    tick();
`else
    access(1'b0, 1'b1, 32'd1024, 32'd0, -1, 18'd0, 32'hDEADBEEF);
`endif

    // Reset asserted during HIGH cycle 1 of a store.
    wr_en      = 1'b1;
    address    = 32'd1044;
    write_data = 32'hCAFEF00D;
    #1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre-reset in HIGH addr", {14'd0, sram_addr}, 32'd11);
    rst   = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("midreset we_n", {31'd0, sram_we_n}, 32'd1);
    chk("midreset dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("midreset ready", {31'd0, ready}, 32'd1);
    chk("midreset read_data", read_data, 32'd0);
    chk("midreset sram_addr", {14'd0, sram_addr}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post-reset idle ready", {31'd0, ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the Mem stage. Services its 32-bit data-memory read/write requests against an external 16-bit asynchronous SRAM.
- Each 32-bit word is split into two 16-bit half-word accesses with programmable wait states.
- `ready` is low while an access is in flight. The core drives pipeline freeze as `~ready`.

Parameters:
- WORD_W, 32, core data/address width
- SRAM_DW, 16, SRAM data width
- SRAM_AW, 18, SRAM address width
- BASE_ADDR, 1024, core byte address mapped to SRAM address 0
- ACCESS_CYCLES, 3, cycles each half-word access is held on the SRAM pins; must be >= 2

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-low (asserted at 0)
- wr_en  in  1  write request from Mem stage
- rd_en  in  1  read request from Mem stage
- address  in  WORD_W  byte address (ALU result)
- write_data  in  WORD_W  store data (Val_Rm)
- read_data  out  WORD_W  load data, valid when ready=1 after a read
- ready  out  1  0 = stall pipeline, 1 = request complete or no request
- sram_addr  out  SRAM_AW  SRAM half-word address
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_dq_out  out  SRAM_DW  data driven to SRAM
- sram_dq_oe  out  1  1 = controller drives the DQ bus
- sram_dq_in  in  SRAM_DW  data returned from SRAM

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, read_data=0, sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
- Address map:
  - offset = address - BASE_ADDR, truncated to WORD_W bits.
  - sram_addr = {offset[SRAM_AW:2], half}, with half=0 for the low half-word and 1 for the high half-word.
  - Bits [1:0] are ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en|rd_en, latch op (write wins if both asserted), address and write_data, then go to LOW. Counter=0.
  - LOW: drive half=0 for ACCESS_CYCLES cycles, then go to HIGH.
  - HIGH: same for half=1, then go to DONE.
  - DONE: one cycle, then IDLE.
- ready = ~(wr_en|rd_en) when in IDLE; 0 in LOW/HIGH; 1 in DONE.
- Latency: ready stays low for 2*ACCESS_CYCLES+1 cycles from the first cycle a request is seen. With the default of 3, ready is high on cycle 7 (0-indexed).
- Write phase:
  - sram_dq_oe=1 and sram_dq_out = latched half-word (write_data[15:0] in LOW, [31:16] in HIGH) for the whole phase.
  - sram_we_n=0 for phase cycles 0..ACCESS_CYCLES-2 and 1 on the last cycle (data hold).
- Read phase:
  - sram_dq_oe=0, sram_we_n=1.
  - sram_dq_in is sampled on the last cycle of the phase into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
  - read_data holds until the next read completes; writes leave it unchanged.
- Request dropped mid-access: the access completes anyway (no abort) and DONE is still visited.
- Request still asserted in DONE: treated as consumed. The next IDLE cycle starts a new access only if the request is still present; the pipeline has advanced, so it is the next instruction's request.
- Reset mid-access: immediate return to reset values. A partially written SRAM word is permitted.

Optional Feature:
- SRAM_READ_CACHE_EN defined:
  - One-entry buffer {valid, word address, data} is filled on every completed read.
  - A read in IDLE whose offset[SRAM_AW:2] matches with valid=1 returns the buffered data with ready=1 in the same cycle (combinational) and the FSM stays in IDLE.
  - Any write to a matching address clears valid; reset clears valid.
- Not defined: every read takes the full SRAM sequence.

Decomposition:
- Package arm_mem_pkg holds:
  - the state enum {IDLE, LOW, HIGH, DONE}
  - WORD_W, SRAM_DW, SRAM_AW defaults
  - BASE_ADDR constant
- One natural sub-module, sram_phase_counter: counts 0..ACCESS_CYCLES-1 with load/clear and emits a last_cycle flag.

Test Plan:
- Reset: rst=0 mid-write at HIGH cycle 1 -> sram_we_n=1, sram_dq_oe=0, ready=1 (no request), state IDLE within the same cycle.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF ->
  - sram_addr=0 carries 0xBEEF and sram_addr=1 carries 0xDEAD.
  - we_n low for 2 of 3 cycles per phase.
  - ready high on cycle 7.
- Read back: rd_en=1, address=1024 -> read_data=0xDEADBEEF with ready=1 on cycle 7; ready=0 on cycles 0..6.
- Address map: rd_en at address=1036 -> sram_addr 6 then 7; address bits [1:0]=3 give the same result.
- Both enables: wr_en=rd_en=1, write_data=0x12345678 -> write performed, read_data unchanged.
- Request dropped: rd_en deasserted in LOW -> access completes, DONE reached, read_data updated. With SRAM_READ_CACHE_EN, a repeat read of 1024 -> ready=1 in cycle 0 with 0xDEADBEEF.
